// File: rtl/static_var_call_sched.sv
// Shared call unit: round-robin arbitration of function calls over static/automatic
// variable slots, sequenced IDLE -> EXEC -> RESP, returning the post-increment value.
module static_var_call_sched #(
    parameter int          NREQ  = 4,
    parameter int          NFUNC = 4,
    parameter int          W     = 32,
    parameter int unsigned INIT  = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NREQ-1:0]                  req_valid,
    input  logic [NREQ*$clog2(NFUNC)-1:0]    req_fid,
    input  logic [NREQ-1:0]                  req_auto,
    output logic [NREQ-1:0]                  req_ready,
    input  logic                             clr_valid,
    input  logic [$clog2(NFUNC)-1:0]         clr_fid,
    output logic                             rsp_valid,
    output logic [$clog2(NREQ)-1:0]          rsp_id,
    output logic [W-1:0]                     rsp_data,
    output logic                             busy
);

    localparam int          FW     = $clog2(NFUNC);
    localparam int          IW     = $clog2(NREQ);
    localparam logic [W-1:0] INIT_W = W'(INIT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESP
    } state_t;

    state_t          state;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   g_q;
    logic [FW-1:0]   fid_q;
    logic            auto_q;
    logic [W-1:0]    slots [NFUNC];

    logic            grant_any;
    logic [IW-1:0]   grant_idx;
    logic [FW-1:0]   grant_fid;
    logic            grant_auto;
    logic [IW-1:0]   scan_idx;
    int              scan_sum;
    logic [W-1:0]    result;

    // Round-robin scan starting at rr_ptr, wrapping through all requesters.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
        grant_any  = 1'b0;
        grant_idx  = '0;
        grant_fid  = '0;
        grant_auto = 1'b0;
        scan_sum   = 0;
        scan_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_sum = int'(rr_ptr) + k;
            scan_idx = IW'(scan_sum % NREQ);
            if (!grant_any && req_valid[scan_idx]) begin
                grant_any = 1'b1;
                grant_idx = scan_idx;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == IW'(i)) begin
                grant_fid  = req_fid[i*FW +: FW];
                grant_auto = req_auto[i];
            end
        end
    end

    assign req_ready = (state == S_IDLE && !reset && grant_any) ? (NREQ'(1) << grant_idx) : '0;
    assign result    = (auto_q ? INIT_W : slots[fid_q]) + W'(1);

    // NOTE: sequential state is updated with non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            g_q       <= '0;
            fid_q     <= '0;
            auto_q    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    rsp_valid <= 1'b0;
                    if (grant_any) begin
                        g_q    <= grant_idx;
                        fid_q  <= grant_fid;
                        auto_q <= grant_auto;
                        rr_ptr <= (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
                        busy   <= 1'b1;
                        state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    rsp_valid <= 1'b1;
                    rsp_id    <= g_q;
                    rsp_data  <= result;
                    state     <= S_RESP;
                end
                S_RESP: begin
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
                default: begin
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

    // Static slots: EXEC write-back first, then clear, so a same-slot clear wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the slots are a handful of registers whose reset value is architecturally visible, so they are reset explicitly like any other state.
            for (int f = 0; f < NFUNC; f++) begin
                slots[f] <= INIT_W;
            end
        end else begin
            if (state == S_EXEC && !auto_q) begin
                slots[fid_q] <= result;
            end
            if (clr_valid) begin
                slots[clr_fid] <= INIT_W;
            end
        end
    end

endmodule

// File: tb/tb_static_var_call_sched.sv
// Self-checking bench for static_var_call_sched: directed scenarios plus random calls
// checked against a transaction-level model of slots and round-robin priority.
module tb_static_var_call_sched;

    localparam int INIT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [7:0]  req_fid;
    logic [3:0]  req_auto;
    logic [3:0]  req_ready;
    logic        clr_valid;
    logic [1:0]  clr_fid;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [31:0] rsp_data;
    logic        busy;

    logic [3:0]  w4_req_valid;
    logic [7:0]  w4_req_fid;
    logic [3:0]  w4_req_auto;
    logic [3:0]  w4_req_ready;
    logic        w4_rsp_valid;
    logic [1:0]  w4_rsp_id;
    logic [3:0]  w4_rsp_data;
    logic        w4_busy;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;

    // Model state: slot contents and round-robin pointer
    logic [31:0] m_slot [4];
    int          m_rr;
    int          acc_cyc;
    logic [1:0]  last_id;
    logic [31:0] last_data;

    static_var_call_sched #(.NREQ(4), .NFUNC(4), .W(32), .INIT(INIT)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_fid(req_fid), .req_auto(req_auto), .req_ready(req_ready),
        .clr_valid(clr_valid), .clr_fid(clr_fid),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
    );

    static_var_call_sched #(.NREQ(4), .NFUNC(4), .W(4), .INIT(INIT)) u_dut_w4 (
        .clk(clk), .reset(reset),
        .req_valid(w4_req_valid), .req_fid(w4_req_fid), .req_auto(w4_req_auto), .req_ready(w4_req_ready),
        .clr_valid(1'b0), .clr_fid(2'd0),
        .rsp_valid(w4_rsp_valid), .rsp_id(w4_rsp_id), .rsp_data(w4_rsp_data), .busy(w4_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic apply_reset();
        reset     = 1'b1;
        req_valid = 4'h0;
        clr_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset  = 1'b0;
        for (int f = 0; f < 4; f++) m_slot[f] = INIT;
        m_rr = 0;
    endtask

    // One call through the main DUT; starts and ends 1 time unit after a rising edge with the DUT idle.
    task automatic call(input logic [3:0] vmask, input logic [7:0] fids, input logic [3:0] autos,
                        input bit do_clr, input logic [1:0] cf, input string tag);
        int          g;
        int          idx;
        logic [1:0]  f;
        logic        a;
        logic [31:0] exp;
        bit          got;
        g = -1;
        for (int k = 0; k < 4; k++) begin
            idx = (m_rr + k) % 4;
            if (g < 0 && vmask[idx]) g = idx;
        end
        f   = fids[g*2 +: 2];
        a   = autos[g];
        exp = a ? 32'(INIT + 1) : m_slot[f] + 32'd1;

        req_valid = vmask;
        req_fid   = fids;
        req_auto  = autos;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (req_ready !== 4'h0) got = 1'b1;
        end
        n_checks++;
        if (!got) begin
            $display("FAIL %s accept: no req_ready within 8 cycles, expected grant %0d", tag, g);
            n_fail++;
            @(posedge clk); #1 req_valid = 4'h0;
            return;
        end
        acc_cyc = cyc;
        n_checks++;
        if (req_ready !== (4'b0001 << g)) begin
            $display("FAIL %s grant: req_ready=%b expected %b", tag, req_ready, 4'b0001 << g);
            n_fail++;
        end
        m_rr = (g + 1) % 4;
        if (!a) m_slot[f] = exp;
        if (do_clr) m_slot[cf] = INIT;

        @(posedge clk); #1;
        req_valid[g] = 1'b0;
        if (do_clr) begin
            clr_valid = 1'b1;
            clr_fid   = cf;
        end
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
            $display("FAIL %s exec: rsp_valid=%b busy=%b expected 0 1", tag, rsp_valid, busy);
            n_fail++;
        end
        @(posedge clk); #1 clr_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b1 || cyc - acc_cyc != 2) begin
            $display("FAIL %s latency: rsp_valid=%b after %0d cycles, expected 1 after 2", tag, rsp_valid, cyc - acc_cyc);
            n_fail++;
        end
        n_checks++;
        if (rsp_id !== 2'(g) || rsp_data !== exp) begin
            $display("FAIL %s rsp: id=%0d data=%0d expected id=%0d data=%0d", tag, rsp_id, rsp_data, g, exp);
            n_fail++;
        end
        last_id   = rsp_id;
        last_data = rsp_data;
        @(posedge clk); #1 req_valid = 4'h0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        req_valid = 4'hF;
        req_fid   = 8'h00;
        req_auto  = 4'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_data !== 32'd0) begin
            $display("FAIL reset rsp: valid=%b id=%0d data=%0d expected 0 0 0", rsp_valid, rsp_id, rsp_data);
            n_fail++;
        end
        n_checks++;
        if (busy !== 1'b0 || req_ready !== 4'h0) begin
            $display("FAIL reset ctrl: busy=%b req_ready=%b expected 0 0000", busy, req_ready);
            n_fail++;
        end
        @(posedge clk); #1;
        apply_reset();
    endtask

    task automatic test_static_repeat();
        apply_reset();
        call(4'b0001, 8'b00_00_00_01, 4'h0, 1'b0, 2'd0, "static1");
        n_checks++;
        if (last_data !== 32'd3) begin $display("FAIL static first: got %0d expected 3", last_data); n_fail++; end
        call(4'b0001, 8'b00_00_00_01, 4'h0, 1'b0, 2'd0, "static2");
        n_checks++;
        if (last_data !== 32'd4 || last_id !== 2'd0) begin
            $display("FAIL static second: got %0d id %0d expected 4 id 0", last_data, last_id);
            n_fail++;
        end
    endtask

    task automatic test_auto_repeat();
        apply_reset();
        call(4'b0100, 8'b00_01_00_00, 4'b0100, 1'b0, 2'd0, "auto1");
        call(4'b0100, 8'b00_01_00_00, 4'b0100, 1'b0, 2'd0, "auto2");
        n_checks++;
        if (last_data !== 32'd3) begin $display("FAIL auto second: got %0d expected 3", last_data); n_fail++; end
        call(4'b0100, 8'b00_01_00_00, 4'b0000, 1'b0, 2'd0, "auto_then_static");
        n_checks++;
        if (last_data !== 32'd3 || last_id !== 2'd2) begin
            $display("FAIL auto slot untouched: got %0d id %0d expected 3 id 2", last_data, last_id);
            n_fail++;
        end
    endtask

    task automatic test_round_robin();
        int prev;
        apply_reset();
        prev = -1;
        for (int n = 0; n < 5; n++) begin
            call(4'hF, 8'h00, 4'h0, 1'b0, 2'd0, "rr");
            n_checks++;
            if (last_id !== 2'(n % 4) || last_data !== 32'(3 + n)) begin
                $display("FAIL rr order %0d: id %0d data %0d expected id %0d data %0d", n, last_id, last_data, n % 4, 3 + n);
                n_fail++;
            end
            if (prev >= 0) begin
                n_checks++;
                if (acc_cyc - prev != 3) begin
                    $display("FAIL rr spacing: %0d cycles expected 3", acc_cyc - prev);
                    n_fail++;
                end
            end
            prev = acc_cyc;
        end
    endtask

    task automatic test_clear_collision();
        apply_reset();
        for (int n = 0; n < 3; n++) call(4'b0001, 8'b00_00_00_10, 4'h0, 1'b0, 2'd0, "clr_fill");
        call(4'b0001, 8'b00_00_00_10, 4'h0, 1'b1, 2'd2, "clr_collide");
        n_checks++;
        if (last_data !== 32'd6) begin $display("FAIL clear collide rsp: got %0d expected 6", last_data); n_fail++; end
        call(4'b0001, 8'b00_00_00_10, 4'h0, 1'b0, 2'd0, "clr_after");
        n_checks++;
        if (last_data !== 32'd3) begin $display("FAIL clear after: got %0d expected 3", last_data); n_fail++; end
    endtask

    task automatic test_wrap();
        int  v;
        bit  got;
        apply_reset();
        v = INIT;
        w4_req_fid  = 8'b00_00_00_11;
        w4_req_auto = 4'h0;
        for (int n = 1; n <= 14; n++) begin
            v = (v + 1) % 16;
            w4_req_valid = 4'b0001;
            got = 1'b0;
            for (int i = 0; i < 8 && !got; i++) begin
                @(negedge clk);
                if (w4_req_ready !== 4'h0) got = 1'b1;
            end
            @(posedge clk); #1 w4_req_valid = 4'h0;
            @(negedge clk);
            @(negedge clk);
            n_checks++;
            if (!got || w4_rsp_valid !== 1'b1 || w4_rsp_data !== 4'(v)) begin
                $display("FAIL wrap call %0d: accepted=%0b rsp_valid=%b data=%0d expected %0d", n, got, w4_rsp_valid, w4_rsp_data, v);
                n_fail++;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        apply_reset();
        call(4'b0001, 8'h00, 4'h0, 1'b0, 2'd0, "mid_fill1");
        call(4'b0001, 8'h00, 4'h0, 1'b0, 2'd0, "mid_fill2");
        req_valid = 4'b0001;
        req_fid   = 8'h00;
        req_auto  = 4'h0;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 4'b0001) begin $display("FAIL mid accept: req_ready=%b expected 0001", req_ready); n_fail++; end
        @(posedge clk); #1;
        reset     = 1'b1;
        req_valid = 4'h0;
        seen = 1'b0;
        @(posedge clk); #1 reset = 1'b0;
        for (int f = 0; f < 4; f++) m_slot[f] = INIT;
        m_rr = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin $display("FAIL mid abort: rsp_valid/busy seen high after reset, expected 0"); n_fail++; end
        @(posedge clk); #1;
        call(4'hF, 8'h00, 4'h0, 1'b0, 2'd0, "mid_after");
        n_checks++;
        if (last_data !== 32'd3 || last_id !== 2'd0) begin
            $display("FAIL mid after: data %0d id %0d expected 3 id 0", last_data, last_id);
            n_fail++;
        end
    endtask

    task automatic test_random();
        logic [3:0] vm;
        apply_reset();
        for (int n = 0; n < 60; n++) begin
            vm = 4'($urandom_range(1, 15));
            call(vm, 8'($urandom), 4'($urandom), ($urandom_range(0, 3) == 0), 2'($urandom), "random");
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
        end
    endtask

    initial begin
        reset        = 1'b1;
        req_valid    = 4'h0;
        req_fid      = 8'h00;
        req_auto     = 4'h0;
        clr_valid    = 1'b0;
        clr_fid      = 2'd0;
        w4_req_valid = 4'h0;
        w4_req_fid   = 8'h00;
        w4_req_auto  = 4'h0;
        @(posedge clk); #1;
        test_reset();
        test_static_repeat();
        test_auto_repeat();
        test_round_robin();
        test_clear_collision();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

endmodule
